// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES-128 round sequencer.
package aes_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, INIT, ROUND, DONE} ctrl_state_t;

    localparam int NR_AES128 = 10;

    // GF(2^8) multiply-by-two, used to step the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Control bus between the round sequencer and the AES datapath / SPI load pin.
interface aes_round_ctrl_if;

    logic       load;
    logic       init_en;
    logic       state_en;
    logic       key_en;
    logic       last_round;
    logic [3:0] round;
    logic [7:0] rcon;
    logic       busy;
    logic       done;

    modport master (
        input  load,
        output init_en, state_en, key_en, last_round, round, rcon, busy, done
    );

    modport slave (
        output load,
        input  init_en, state_en, key_en, last_round, round, rcon, busy, done
    );

endinterface

// File: rtl/aes_rcon_gen.sv
// Round index counter and matching Rcon byte register.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       start,
    input  logic       advance,
    output logic [3:0] round,
    output logic [7:0] rcon
);

    // clear wins over start so an aborted INIT never leaves a stale round 1
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            round <= 4'd0;
            rcon  <= 8'h01;
        end else if (start) begin
            round <= 4'd1;
            rcon  <= 8'h01;
        end else if (advance) begin
            round <= round + 4'd1;
            rcon  <= xtime(rcon);
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for an iterative one-round-per-pass AES-128 datapath with sync-sbox latency.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR       = NR_AES128,
    parameter int SBOX_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    aes_round_ctrl_if.master bus
);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_LOAD  = LOAD;
    localparam logic [2:0] ST_INIT  = INIT;
    localparam logic [2:0] ST_ROUND = ROUND;
    localparam logic [2:0] ST_DONE  = DONE;

    localparam int              CW         = ($clog2(SBOX_LAT + 1) < 1) ? 1 : $clog2(SBOX_LAT + 1);
    localparam logic [CW-1:0]   CNT_MAX    = CW'(SBOX_LAT);
    localparam logic [3:0]      ROUND_LAST = 4'(NR);

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [CW-1:0] cnt;
    logic          capture;
    logic [3:0]    round;
    logic [7:0]    rcon;

    assign capture = (state == ST_ROUND) && (cnt == CNT_MAX);

    // load high from any state aborts the run and parks the FSM in LOAD
    always_comb begin
        next_state = state;
        if (bus.load) begin
            next_state = ST_LOAD;
        end else begin
            case (state)
                ST_IDLE:  next_state = ST_IDLE;
                ST_LOAD:  next_state = ST_INIT;
                ST_INIT:  next_state = ST_ROUND;
                ST_ROUND: if (capture && round == ROUND_LAST) next_state = ST_DONE;
                ST_DONE:  next_state = ST_DONE;
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == ST_ROUND && next_state == ST_ROUND && !capture)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

    aes_rcon_gen u_rcon_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (next_state != ST_ROUND),
        .start   (state == ST_INIT && next_state == ST_ROUND),
        .advance (capture && next_state == ST_ROUND),
        .round   (round),
        .rcon    (rcon)
    );

    assign bus.init_en    = (state == ST_INIT);
    assign bus.state_en   = capture;
    assign bus.key_en     = capture;
    assign bus.last_round = (state == ST_ROUND) && (round == ROUND_LAST);
    assign bus.busy       = (state == ST_INIT) || (state == ST_ROUND);
    assign bus.done       = (state == ST_DONE);
    assign bus.round      = round;
    assign bus.rcon       = rcon;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench: per-cycle timing checks plus a capture scoreboard for two latencies.
module tb_aes_round_ctrl;

    localparam int NR = 10;

    typedef struct {
        int         cyc;
        logic [3:0] round;
        logic [7:0] rcon;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   base_a = 0;
    int   base_b = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a;
    exp_t e_b;
    logic [7:0] rcon_tab [NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    aes_round_ctrl_if bus_a ();
    aes_round_ctrl_if bus_b ();

    aes_round_ctrl #(.NR(NR), .SBOX_LAT(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    aes_round_ctrl #(.NR(NR), .SBOX_LAT(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every capture pulse must match the next expected round record
    always @(negedge clk) begin
        if (bus_a.state_en === 1'b1 || bus_a.key_en === 1'b1) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("[TB] FAIL cap_a_unexpected: capture at cycle %0d round %0d, required none", cyc - base_a, bus_a.round);
            end else begin
                e_a = q_a.pop_front();
                if ((cyc - base_a) != e_a.cyc || bus_a.round !== e_a.round || bus_a.rcon !== e_a.rcon ||
                    bus_a.last_round !== e_a.last || bus_a.state_en !== 1'b1 || bus_a.key_en !== 1'b1 ||
                    bus_a.init_en !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL cap_a: got cyc %0d round %0d rcon %h last %b se %b ke %b ie %b, required cyc %0d round %0d rcon %h last %b se 1 ke 1 ie 0",
                             cyc - base_a, bus_a.round, bus_a.rcon, bus_a.last_round, bus_a.state_en, bus_a.key_en,
                             bus_a.init_en, e_a.cyc, e_a.round, e_a.rcon, e_a.last);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.state_en === 1'b1 || bus_b.key_en === 1'b1) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("[TB] FAIL cap_b_unexpected: capture at cycle %0d round %0d, required none", cyc - base_b, bus_b.round);
            end else begin
                e_b = q_b.pop_front();
                if ((cyc - base_b) != e_b.cyc || bus_b.round !== e_b.round || bus_b.rcon !== e_b.rcon ||
                    bus_b.last_round !== e_b.last || bus_b.state_en !== 1'b1 || bus_b.key_en !== 1'b1 ||
                    bus_b.init_en !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL cap_b: got cyc %0d round %0d rcon %h last %b, required cyc %0d round %0d rcon %h last %b",
                             cyc - base_b, bus_b.round, bus_b.rcon, bus_b.last_round,
                             e_b.cyc, e_b.round, e_b.rcon, e_b.last);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_run(input bit sel_b, input int lat);
        exp_t e;
        for (int r = 1; r <= NR; r++) begin
            e.cyc   = 1 + r * (lat + 1);
            e.round = 4'(r);
            e.rcon  = rcon_tab[r-1];
            e.last  = (r == NR);
            if (sel_b) q_b.push_back(e);
            else       q_a.push_back(e);
        end
    endtask

    // called just after a posedge while dut_a sits in LOAD: this cycle becomes cycle 0
    task automatic start_run_a();
        bus_a.load = 1'b0;
        base_a     = cyc;
        push_run(1'b0, 1);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus_a.load = 1'b0;
        bus_b.load = 1'b0;
        tick(3);
        @(negedge clk);
        checks++;
        if ({bus_a.init_en, bus_a.state_en, bus_a.key_en, bus_a.last_round, bus_a.busy, bus_a.done} !== 6'b0 ||
            bus_a.round !== 4'd0 || bus_a.rcon !== 8'h01) begin
            errors++;
            $display("[TB] FAIL reset_a: ctl %b round %0d rcon %h, required ctl 000000 round 0 rcon 01",
                     {bus_a.init_en, bus_a.state_en, bus_a.key_en, bus_a.last_round, bus_a.busy, bus_a.done},
                     bus_a.round, bus_a.rcon);
        end
        checks++;
        if ({bus_b.init_en, bus_b.busy, bus_b.done} !== 3'b0 || bus_b.round !== 4'd0 || bus_b.rcon !== 8'h01) begin
            errors++;
            $display("[TB] FAIL reset_b: ie/busy/done %b round %0d rcon %h, required 000 0 01",
                     {bus_b.init_en, bus_b.busy, bus_b.done}, bus_b.round, bus_b.rcon);
        end
        reset = 1'b0;
        tick(2);
        @(negedge clk);
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 || bus_a.init_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: busy %b done %b init %b, required 0 0 0", bus_a.busy, bus_a.done, bus_a.init_en);
        end
    endtask

    task automatic test_full_run();
        int er;
        logic [7:0] xr;
        bus_a.load = 1'b1;
        tick(256);
        @(negedge clk);
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL loading: busy %b done %b, required 0 0", bus_a.busy, bus_a.done);
        end
        tick(1);
        start_run_a();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            er = (c >= 2 && c <= 21) ? c / 2 : 0;
            if (er == 0) xr = 8'h01;
            else         xr = rcon_tab[er-1];
            checks++;
            if (bus_a.init_en !== (c == 1)) begin
                errors++;
                $display("[TB] FAIL run_init_en c%0d: got %b required %b", c, bus_a.init_en, (c == 1));
            end
            checks++;
            if (bus_a.busy !== (c >= 1 && c <= 21)) begin
                errors++;
                $display("[TB] FAIL run_busy c%0d: got %b required %b", c, bus_a.busy, (c >= 1 && c <= 21));
            end
            checks++;
            if (bus_a.done !== (c >= 22)) begin
                errors++;
                $display("[TB] FAIL run_done c%0d: got %b required %b", c, bus_a.done, (c >= 22));
            end
            checks++;
            if (bus_a.last_round !== (c == 20 || c == 21)) begin
                errors++;
                $display("[TB] FAIL run_last c%0d: got %b required %b", c, bus_a.last_round, (c == 20 || c == 21));
            end
            checks++;
            if (bus_a.round !== 4'(er) || bus_a.rcon !== xr) begin
                errors++;
                $display("[TB] FAIL run_round c%0d: got round %0d rcon %h required round %0d rcon %h", c, bus_a.round, bus_a.rcon, er, xr);
            end
        end
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("[TB] FAIL run_captures: %0d captures missing, required 0", q_a.size());
        end
    endtask

    task automatic test_abort();
        tick(1);
        bus_a.load = 1'b1;
        tick(3);
        start_run_a();
        tick(12);
        bus_a.load = 1'b1;
        tick(1);
        q_a.delete();
        for (int c = 13; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.init_en !== 1'b0 || bus_a.round !== 4'd0) begin
                errors++;
                $display("[TB] FAIL abort c%0d: done %b busy %b init %b round %0d, required 0 0 0 0",
                         c, bus_a.done, bus_a.busy, bus_a.init_en, bus_a.round);
            end
        end
        tick(1);
        start_run_a();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            checks++;
            if (bus_a.done !== (c >= 22) || bus_a.init_en !== (c == 1)) begin
                errors++;
                $display("[TB] FAIL rerun c%0d: done %b init %b, required %b %b", c, bus_a.done, bus_a.init_en, (c >= 22), (c == 1));
            end
        end
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("[TB] FAIL rerun_captures: %0d captures missing, required 0", q_a.size());
        end
    endtask

    task automatic test_back_to_back();
        tick(1);
        bus_a.load = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pulse_done_held: got %b required 1", bus_a.done);
        end
        tick(1);
        start_run_a();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            checks++;
            if (bus_a.done !== (c >= 22) || bus_a.init_en !== (c == 1) || bus_a.busy !== (c >= 1 && c <= 21)) begin
                errors++;
                $display("[TB] FAIL b2b c%0d: done %b init %b busy %b, required %b %b %b", c, bus_a.done,
                         bus_a.init_en, bus_a.busy, (c >= 22), (c == 1), (c >= 1 && c <= 21));
            end
        end
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_captures: %0d captures missing, required 0", q_a.size());
        end
    endtask

    task automatic test_reset_midrun();
        tick(1);
        bus_a.load = 1'b1;
        tick(2);
        start_run_a();
        tick(15);
        reset = 1'b1;
        tick(1);
        q_a.delete();
        for (int c = 16; c < 23; c++) begin
            @(negedge clk);
            if (c == 16) reset = 1'b0;
            checks++;
            if ({bus_a.init_en, bus_a.state_en, bus_a.key_en, bus_a.last_round, bus_a.busy, bus_a.done} !== 6'b0 ||
                bus_a.round !== 4'd0 || bus_a.rcon !== 8'h01) begin
                errors++;
                $display("[TB] FAIL midrun_reset c%0d: ctl %b round %0d rcon %h, required ctl 000000 round 0 rcon 01", c,
                         {bus_a.init_en, bus_a.state_en, bus_a.key_en, bus_a.last_round, bus_a.busy, bus_a.done},
                         bus_a.round, bus_a.rcon);
            end
        end
    endtask

    task automatic test_sbox_lat2();
        int er;
        bus_b.load = 1'b1;
        tick(3);
        bus_b.load = 1'b0;
        base_b     = cyc;
        push_run(1'b1, 2);
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            er = (c >= 2 && c <= 31) ? (c + 1) / 3 : 0;
            checks++;
            if (bus_b.init_en !== (c == 1) || bus_b.busy !== (c >= 1 && c <= 31) || bus_b.done !== (c >= 32)) begin
                errors++;
                $display("[TB] FAIL lat2_ctl c%0d: init %b busy %b done %b, required %b %b %b", c, bus_b.init_en,
                         bus_b.busy, bus_b.done, (c == 1), (c >= 1 && c <= 31), (c >= 32));
            end
            checks++;
            if (bus_b.round !== 4'(er) || bus_b.last_round !== (c >= 29 && c <= 31)) begin
                errors++;
                $display("[TB] FAIL lat2_round c%0d: round %0d last %b, required %0d %b", c, bus_b.round,
                         bus_b.last_round, er, (c >= 29 && c <= 31));
            end
        end
        checks++;
        if (q_b.size() != 0) begin
            errors++;
            $display("[TB] FAIL lat2_captures: %0d captures missing, required 0", q_b.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        test_sbox_lat2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
